// File: rtl/pulse_rate_counter_if.sv
// Bundles the pulse_rate_counter data, control and result signals.
// Latency: none (wires only).
// Backpressure: the result side is a valid/ready pair (rate_valid / rate_ready).
//
// Optional feature macro: PULSE_RATE_PEAK_EN adds rate_peak (max pulse_count in the window).
// Signals: valid_in, pulse_count (upstream beat); gate_beats, continuous,
// start, stop (control); rate_out, rate_valid, rate_ready, rate_sat,
// overrun, busy (result and status).
interface pulse_rate_counter_if #(
  parameter int CNT_WIDTH  = 32,
  parameter int GATE_WIDTH = 24
);
  logic                  valid_in;
  logic [4:0]            pulse_count;
  logic [GATE_WIDTH-1:0] gate_beats;
  logic                  continuous;
  logic                  start;
  logic                  stop;
  logic [CNT_WIDTH-1:0]  rate_out;
  logic                  rate_valid;
  logic                  rate_ready;
  logic                  rate_sat;
  logic                  overrun;
  logic                  busy;
`ifdef PULSE_RATE_PEAK_EN
  logic [4:0]            rate_peak;

  // master: the side driving beats/control and consuming results
  modport master (
    output valid_in, pulse_count, gate_beats, continuous, start, stop, rate_ready,
    input  rate_out, rate_valid, rate_sat, overrun, busy, rate_peak
  );
  // slave: the counter itself
  modport slave (
    input  valid_in, pulse_count, gate_beats, continuous, start, stop, rate_ready,
    output rate_out, rate_valid, rate_sat, overrun, busy, rate_peak
  );
`else
  modport master (
    output valid_in, pulse_count, gate_beats, continuous, start, stop, rate_ready,
    input  rate_out, rate_valid, rate_sat, overrun, busy
  );
  modport slave (
    input  valid_in, pulse_count, gate_beats, continuous, start, stop, rate_ready,
    output rate_out, rate_valid, rate_sat, overrun, busy
  );
`endif
endinterface

// File: rtl/pulse_rate_counter.sv
// Gated accumulator: sums per-beat pulse counts over a window of gate_reg valid beats.
// Latency: rate_valid rises 1 cycle after the closing beat; busy follows start/close/stop by 1 cycle.
// Backpressure: 1-deep result register; a close while a result is held and not consumed drops the new result and sets overrun.
//
// Optional feature macro: PULSE_RATE_PEAK_EN (adds bus.rate_peak, the max pulse_count of the window).
// Ports: clk, rst (async active-high); bus (pulse_rate_counter_if.slave) carrying
// beat input, window control, the valid/ready result register and status.
module pulse_rate_counter #(
  parameter int CNT_WIDTH  = 32,
  parameter int GATE_WIDTH = 24
) (
  input logic                 clk,
  input logic                 rst,
  pulse_rate_counter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  acc_q, acc_d;
  logic                  win_sat_q, win_sat_d;
  logic [GATE_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [GATE_WIDTH-1:0] gate_q, gate_d;
  logic [CNT_WIDTH-1:0]  rate_out_q, rate_out_d;
  logic                  rate_valid_q, rate_valid_d;
  logic                  rate_sat_q, rate_sat_d;
  logic                  overrun_q, overrun_d;
`ifdef PULSE_RATE_PEAK_EN
  logic [4:0]            peak_q, peak_d, peak_new;
  logic [4:0]            rate_peak_q, rate_peak_d;
`endif

  logic [CNT_WIDTH:0]    sum_w;
  logic [CNT_WIDTH-1:0]  sum_sat;
  logic                  sum_ovf;
  logic                  start_go, count_beat, closing, load, accept;

  // One extra bit catches the carry out; clamp to all-ones when it is set.
  assign sum_w   = {1'b0, acc_q} + {{(CNT_WIDTH-4){1'b0}}, bus.pulse_count};
  assign sum_ovf = sum_w[CNT_WIDTH];
  assign sum_sat = sum_ovf ? '1 : sum_w[CNT_WIDTH-1:0];

  assign start_go   = (state_q == IDLE) && bus.start && !bus.stop;
  // stop in COUNT pre-empts any beat, including a closing one
  assign count_beat = (state_q == COUNT) && bus.valid_in && !bus.stop;
  assign closing    = count_beat && (beat_cnt_q == gate_q - GATE_WIDTH'(1));
  assign accept     = rate_valid_q && bus.rate_ready;
  // A result held this cycle can still make room if it is consumed now.
  assign load       = closing && (!rate_valid_q || bus.rate_ready);

`ifdef PULSE_RATE_PEAK_EN
  assign peak_new = (bus.pulse_count > peak_q) ? bus.pulse_count : peak_q;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = COUNT;
      COUNT: begin
        if (bus.stop)                          state_d = IDLE;
        else if (closing && !bus.continuous)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.busy       = (state_q == COUNT);
    bus.rate_out   = rate_out_q;
    bus.rate_valid = rate_valid_q;
    bus.rate_sat   = rate_sat_q;
    bus.overrun    = overrun_q;
`ifdef PULSE_RATE_PEAK_EN
    bus.rate_peak  = rate_peak_q;
`endif
  end

  // window datapath and result register
  always_comb begin
    acc_d        = acc_q;
    win_sat_d    = win_sat_q;
    beat_cnt_d   = beat_cnt_q;
    gate_d       = gate_q;
    rate_out_d   = rate_out_q;
    rate_valid_d = rate_valid_q;
    rate_sat_d   = rate_sat_q;
    overrun_d    = overrun_q;
`ifdef PULSE_RATE_PEAK_EN
    peak_d       = peak_q;
    rate_peak_d  = rate_peak_q;
`endif

    if (start_go) begin
      gate_d     = (bus.gate_beats == '0) ? GATE_WIDTH'(1) : bus.gate_beats;
      acc_d      = '0;
      win_sat_d  = 1'b0;
      beat_cnt_d = '0;
      overrun_d  = 1'b0;
`ifdef PULSE_RATE_PEAK_EN
      peak_d     = '0;
`endif
    end else if ((state_q == COUNT) && bus.stop) begin
      acc_d      = '0;
      win_sat_d  = 1'b0;
      beat_cnt_d = '0;
`ifdef PULSE_RATE_PEAK_EN
      peak_d     = '0;
`endif
    end else if (count_beat) begin
      if (closing) begin
        // a following window (continuous) starts from zero with no gap
        acc_d      = '0;
        win_sat_d  = 1'b0;
        beat_cnt_d = '0;
`ifdef PULSE_RATE_PEAK_EN
        peak_d     = '0;
`endif
      end else begin
        acc_d      = sum_sat;
        win_sat_d  = win_sat_q | sum_ovf;
        beat_cnt_d = beat_cnt_q + GATE_WIDTH'(1);
`ifdef PULSE_RATE_PEAK_EN
        peak_d     = peak_new;
`endif
      end
    end

    if (load) begin
      rate_out_d   = sum_sat;
      rate_sat_d   = win_sat_q | sum_ovf;
      rate_valid_d = 1'b1;
`ifdef PULSE_RATE_PEAK_EN
      rate_peak_d  = peak_new;
`endif
    end else if (accept) begin
      rate_valid_d = 1'b0;
    end

    if (closing && !load) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q        <= '0;
      win_sat_q    <= 1'b0;
      beat_cnt_q   <= '0;
      gate_q       <= '0;
      rate_out_q   <= '0;
      rate_valid_q <= 1'b0;
      rate_sat_q   <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef PULSE_RATE_PEAK_EN
      peak_q       <= '0;
      rate_peak_q  <= '0;
`endif
    end else begin
      acc_q        <= acc_d;
      win_sat_q    <= win_sat_d;
      beat_cnt_q   <= beat_cnt_d;
      gate_q       <= gate_d;
      rate_out_q   <= rate_out_d;
      rate_valid_q <= rate_valid_d;
      rate_sat_q   <= rate_sat_d;
      overrun_q    <= overrun_d;
`ifdef PULSE_RATE_PEAK_EN
      peak_q       <= peak_d;
      rate_peak_q  <= rate_peak_d;
`endif
    end
  end

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Bench for pulse_rate_counter: scenario tasks drive a main instance and a narrow (5-bit) instance.
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled then or on the falling edge.
// Backpressure: a falling-edge monitor pops the expected-result queue on every rate_valid & rate_ready.
module tb_pulse_rate_counter;

  typedef struct {
    logic [31:0] out;
    logic        sat;
    logic [4:0]  peak;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t sb[$];

  pulse_rate_counter_if #(.CNT_WIDTH(32), .GATE_WIDTH(24)) bus ();
  pulse_rate_counter_if #(.CNT_WIDTH(5),  .GATE_WIDTH(24)) bus5 ();

  pulse_rate_counter #(.CNT_WIDTH(32), .GATE_WIDTH(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pulse_rate_counter #(.CNT_WIDTH(5), .GATE_WIDTH(24)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every handshake on the main instance must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rate_valid && bus.rate_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: rate_out=%0d delivered, no result expected", bus.rate_out);
      end else begin
        e = sb.pop_front();
        if (bus.rate_out !== e.out) begin
          errors++;
          $display("FAIL sb_rate_out: got %0d, expected %0d", bus.rate_out, e.out);
        end
        checks++;
        if (bus.rate_sat !== e.sat) begin
          errors++;
          $display("FAIL sb_rate_sat: got %0b, expected %0b", bus.rate_sat, e.sat);
        end
`ifdef PULSE_RATE_PEAK_EN
        checks++;
        if (bus.rate_peak !== e.peak) begin
          errors++;
          $display("FAIL sb_rate_peak: got %0d, expected %0d", bus.rate_peak, e.peak);
        end
`endif
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] o, input logic s, input logic [4:0] p);
    exp_t e;
    e.out = o; e.sat = s; e.peak = p;
    sb.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected results never delivered, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.rate_out !== 32'd0) begin
      errors++; $display("FAIL reset_rate_out: got %0d, expected 0", bus.rate_out);
    end
    check_bit("reset_rate_valid", bus.rate_valid, 1'b0);
    check_bit("reset_rate_sat", bus.rate_sat, 1'b0);
    check_bit("reset_overrun", bus.overrun, 1'b0);
    check_bit("reset_busy", bus.busy, 1'b0);
`ifdef PULSE_RATE_PEAK_EN
    checks++;
    if (bus.rate_peak !== 5'd0) begin
      errors++; $display("FAIL reset_rate_peak: got %0d, expected 0", bus.rate_peak);
    end
`endif
  endtask

  task automatic test_single_shot();
    bus.rate_ready = 1'b1;
    bus.gate_beats = 24'd4;
    bus.continuous = 1'b0;
    bus.start = 1'b1; bus.valid_in = 1'b1; bus.pulse_count = 5'd7; // same-cycle beat is not counted
    cycle();
    bus.start = 1'b0;
    check_bit("single_busy_rise", bus.busy, 1'b1);
    push(32'd24, 1'b0, 5'd16);
    bus.pulse_count = 5'd3;  cycle();
    bus.valid_in = 1'b0; bus.pulse_count = 5'd31; cycle(); // idle beat ignored
    bus.valid_in = 1'b1;
    bus.pulse_count = 5'd0;  cycle();
    bus.pulse_count = 5'd5;  cycle();
    bus.pulse_count = 5'd16; cycle();
    check_bit("single_rate_valid", bus.rate_valid, 1'b1);
    check_bit("single_busy_fall", bus.busy, 1'b0);
    bus.pulse_count = 5'd9; cycle(); cycle();
    bus.valid_in = 1'b0;
    check_bit("single_after_valid", bus.rate_valid, 1'b0);
    check_bit("single_after_busy", bus.busy, 1'b0);
    check_empty("single_sb_empty");
  endtask

  task automatic test_continuous_backpressure();
    bus.rate_ready = 1'b0;
    bus.gate_beats = 24'd2;
    bus.continuous = 1'b1;
    bus.valid_in = 1'b1; bus.pulse_count = 5'd1;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    push(32'd2, 1'b0, 5'd1);   // first window, held
    push(32'd2, 1'b0, 5'd1);   // third window, loaded on the consuming cycle
    cycle();
    cycle();                   // first close
    check_bit("cont_valid_first", bus.rate_valid, 1'b1);
    checks++;
    if (bus.rate_out !== 32'd2) begin
      errors++; $display("FAIL cont_out_first: got %0d, expected 2", bus.rate_out);
    end
    cycle();
    check_bit("cont_overrun_before", bus.overrun, 1'b0);
    cycle();                   // second close, dropped
    check_bit("cont_overrun_set", bus.overrun, 1'b1);
    checks++;
    if (bus.rate_out !== 32'd2) begin
      errors++; $display("FAIL cont_out_held: got %0d, expected 2", bus.rate_out);
    end
    cycle();
    bus.rate_ready = 1'b1;
    cycle();                   // third close with consume
    check_bit("cont_valid_reload", bus.rate_valid, 1'b1);
    check_bit("cont_overrun_sticky", bus.overrun, 1'b1);
    bus.stop = 1'b1; bus.valid_in = 1'b0;
    cycle();
    bus.stop = 1'b0;
    check_bit("cont_stop_busy", bus.busy, 1'b0);
    check_bit("cont_drained", bus.rate_valid, 1'b0);
    check_empty("cont_sb_empty");
  endtask

  task automatic test_back_to_back();
    bus.rate_ready = 1'b1;
    bus.gate_beats = 24'd1;
    bus.continuous = 1'b1;
    bus.valid_in = 1'b1; bus.pulse_count = 5'd4;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.pulse_count = 5'((i * 7) % 32);
      push(32'((i * 7) % 32), 1'b0, 5'((i * 7) % 32));
      cycle();
    end
    bus.stop = 1'b1; bus.valid_in = 1'b0;
    cycle();
    bus.stop = 1'b0;
    cycle();
    check_bit("b2b_overrun", bus.overrun, 1'b0);
    check_bit("b2b_valid", bus.rate_valid, 1'b0);
    check_empty("b2b_sb_empty");
  endtask

  task automatic test_stop_collision();
    bus.rate_ready = 1'b1;
    bus.gate_beats = 24'd3;
    bus.continuous = 1'b0;
    bus.start = 1'b1; bus.valid_in = 1'b0;
    cycle();
    bus.start = 1'b0;
    bus.valid_in = 1'b1; bus.pulse_count = 5'd1;
    cycle(); cycle();
    bus.stop = 1'b1;           // collides with the closing beat
    cycle();
    bus.stop = 1'b0; bus.valid_in = 1'b0;
    check_bit("stop_busy", bus.busy, 1'b0);
    check_bit("stop_no_valid", bus.rate_valid, 1'b0);
    check_bit("stop_no_overrun", bus.overrun, 1'b0);
    bus.start = 1'b1; bus.stop = 1'b1;
    cycle();
    bus.start = 1'b0; bus.stop = 1'b0;
    check_bit("startstop_busy", bus.busy, 1'b0);
    bus.valid_in = 1'b1; bus.pulse_count = 5'd5;
    cycle(); cycle(); cycle();
    bus.valid_in = 1'b0;
    cycle();
    check_bit("startstop_no_valid", bus.rate_valid, 1'b0);
    check_empty("stop_sb_empty");
  endtask

  task automatic test_saturation();
    bool_wait: begin end
    bus5.rate_ready = 1'b0;
    bus5.gate_beats = 24'd3;
    bus5.continuous = 1'b0;
    bus5.start = 1'b1;
    cycle();
    bus5.start = 1'b0;
    bus5.valid_in = 1'b1; bus5.pulse_count = 5'd16;
    cycle(); cycle(); cycle();
    bus5.valid_in = 1'b0;
    for (int i = 0; i < 5 && !bus5.rate_valid; i++) cycle();
    check_bit("sat_valid", bus5.rate_valid, 1'b1);
    checks++;
    if (bus5.rate_out !== 5'd31) begin
      errors++; $display("FAIL sat_rate_out: got %0d, expected 31", bus5.rate_out);
    end
    check_bit("sat_flag", bus5.rate_sat, 1'b1);
  endtask

  task automatic test_peak();
    bus.rate_ready = 1'b1;
    bus.gate_beats = 24'd3;
    bus.continuous = 1'b0;
    bus.start = 1'b1; bus.valid_in = 1'b0;
    cycle();
    bus.start = 1'b0;
    push(32'd15, 1'b0, 5'd9);
    bus.valid_in = 1'b1;
    bus.pulse_count = 5'd2; cycle();
    bus.pulse_count = 5'd9; cycle();
    bus.pulse_count = 5'd4; cycle();
    bus.valid_in = 1'b0;
    check_bit("peak_valid", bus.rate_valid, 1'b1);
    cycle();
    check_empty("peak_sb_empty");
  endtask

  task automatic test_reset_mid_window();
    bus.rate_ready = 1'b0;
    bus.gate_beats = 24'd100;
    bus.continuous = 1'b0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.valid_in = 1'b1; bus.pulse_count = 5'd1;
    for (int i = 0; i < 50; i++) cycle();
    check_bit("rstmid_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rate_out !== 32'd0) begin
      errors++; $display("FAIL rstmid_rate_out: got %0d, expected 0", bus.rate_out);
    end
    check_bit("rstmid_busy", bus.busy, 1'b0);
    check_bit("rstmid_valid", bus.rate_valid, 1'b0);
    check_bit("rstmid_overrun", bus.overrun, 1'b0);
    bus.valid_in = 1'b0;
    cycle();
    rst = 1'b0;
    bus.gate_beats = 24'd0;
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.rate_ready = 1'b1;
    bus.valid_in = 1'b1; bus.pulse_count = 5'd13;
    push(32'd13, 1'b0, 5'd13);
    cycle();
    bus.valid_in = 1'b0;
    check_bit("gate0_valid", bus.rate_valid, 1'b1);
    check_bit("gate0_busy", bus.busy, 1'b0);
    cycle();
    check_empty("gate0_sb_empty");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.pulse_count = '0; bus.gate_beats = '0;
    bus.continuous = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.rate_ready = 1'b0;
    bus5.valid_in = 1'b0; bus5.pulse_count = '0; bus5.gate_beats = '0;
    bus5.continuous = 1'b0; bus5.start = 1'b0; bus5.stop = 1'b0; bus5.rate_ready = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    test_reset();
    test_single_shot();
    test_continuous_backpressure();
    test_back_to_back();
    test_stop_collision();
    test_saturation();
    test_peak();
    test_reset_mid_window();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
